// File: rtl/aes_inv_round_serial.sv
// aes_inv_round_serial: column-serial AES inverse round engine with an external inverse S-box
module aes_inv_round_serial #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       round_mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] round_key,
  output logic [31:0]      sbox_addr,
  input  logic [31:0]      sbox_data,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, COL, FIN} state_t;
  state_t state;
  logic [1:0] col, mode;
  logic [WIDTH-1:0] st, key, res;
  logic [31:0] kw, sw, t, mixed, col_res;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^ (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
  endfunction

  // {~col,5'h1f} is 127-32*col: the MSB of word col
  assign kw = key[{~col, 5'h1f} -: 32];
  assign sw = st[{~col, 5'h1f} -: 32];
  assign t  = sbox_data ^ kw;

  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [3:0] b;
    assign b = {col - 2'(r), 2'(r)};
    assign sbox_addr[31-8*r -: 8] = state == COL ? st[{~b, 3'b111} -: 8] : 8'h00;
    assign mixed[31-8*r -: 8] = gm(t[31-8*r -: 8], 4'he) ^ gm(t[31-8*((r+1)%4) -: 8], 4'hb)
                              ^ gm(t[31-8*((r+2)%4) -: 8], 4'hd) ^ gm(t[31-8*((r+3)%4) -: 8], 4'h9);
  end

  assign col_res = mode == 2'd2 ? sw ^ kw : mode == 2'd1 ? t : mixed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      col      <= '0;
      mode     <= '0;
      st       <= '0;
      key      <= '0;
      res      <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          st    <= data_in;
          key   <= round_key;
          mode  <= round_mode;
          busy  <= 1'b1;
          col   <= '0;
          state <= COL;
        end
        COL: begin
          res[{~col, 5'h1f} -: 32] <= col_res;
          col <= col + 2'd1;
          if (col == 2'd3) state <= FIN;
        end
        default: begin
          data_out <= res;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_round_serial.sv
// tb_aes_inv_round_serial: randomized and directed checks against a byte-level AES inverse-round model
module tb_aes_inv_round_serial;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, id_sbox = 1'b0;
  logic [1:0] round_mode = '0;
  logic [127:0] data_in = '0, round_key = '0, data_out;
  logic [31:0] sbox_addr, sbox_data;
  logic busy, done;
  logic [7:0] inv_sb [256];
  int tests = 0, fails = 0;

  aes_inv_round_serial #(.WIDTH(128)) dut (
    .clk(clk), .reset(reset), .start(start), .round_mode(round_mode),
    .data_in(data_in), .round_key(round_key), .sbox_addr(sbox_addr),
    .sbox_data(sbox_data), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign sbox_data = id_sbox ? sbox_addr : {inv_sb[sbox_addr[31:24]], inv_sb[sbox_addr[23:16]],
                                            inv_sb[sbox_addr[15:8]], inv_sb[sbox_addr[7:0]]};

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // forward S-box = affine(multiplicative inverse); the inverse table is its inversion
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_sb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                         input logic [1:0] m, input logic ident);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] o [16];
    logic [127:0] q;
    if (m == 2'd2) return d ^ k;
    for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c - r + 4) % 4) + r];
    for (int i = 0; i < 16; i++) t[i] = (ident ? t[i] : inv_sb[t[i]]) ^ k[127-8*i -: 8];
    o = t;
    if (m != 2'd1)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[4*c+r] = mul(t[4*c+r], 8'h0e) ^ mul(t[4*c+(r+1)%4], 8'h0b)
                   ^ mul(t[4*c+(r+2)%4], 8'h0d) ^ mul(t[4*c+(r+3)%4], 8'h09);
    for (int i = 0; i < 16; i++) q[127-8*i -: 8] = o[i];
    return q;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept one request, scramble the live inputs, then wait (bounded) for done
  task automatic run_op(input logic [127:0] d, input logic [127:0] k, input logic [1:0] m,
                        output logic [127:0] q, output int lat);
    data_in = d;
    round_key = k;
    round_mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    data_in = rnd128();
    round_key = rnd128();
    round_mode = 2'($urandom_range(0, 3));
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    q = data_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (data_out !== '0) begin fails++; $display("FAIL reset_data_out got %h exp 0", data_out); end
    tests++; if (sbox_addr !== '0) begin fails++; $display("FAIL reset_sbox_addr got %h exp 0", sbox_addr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mode2();
    logic [127:0] q;
    int lat;
    id_sbox = 1'b0;
    run_op(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5, 2'd2, q, lat);
    tests++; if (lat !== 5) begin fails++; $display("FAIL mode2_latency got %0d exp 5", lat); end
    tests++; if (q !== 128'h7ad5fda789ef4e272bca100b3d9ff59f) begin
      fails++; $display("FAIL mode2_data got %h exp 7ad5fda789ef4e272bca100b3d9ff59f", q);
    end
    tick();
  endtask

  task automatic test_mode1();
    int lat;
    id_sbox = 1'b0;
    data_in = 128'h6353e08c0960e104cd70b751bacad0e7;
    round_key = 128'h000102030405060708090a0b0c0d0e0f;
    round_mode = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mode1_busy got %b exp 1", busy); end
    tests++; if (sbox_addr !== 32'h63cab704) begin fails++; $display("FAIL mode1_sbox_addr got %h exp 63cab704", sbox_addr); end
    lat = 0;
    while (!done && lat < 20) begin tick(); lat++; end
    tests++; if (lat !== 5) begin fails++; $display("FAIL mode1_latency got %0d exp 5", lat); end
    tests++; if (data_out !== 128'h00112233445566778899aabbccddeeff) begin
      fails++; $display("FAIL mode1_data got %h exp 00112233445566778899aabbccddeeff", data_out);
    end
    tick();
  endtask

  task automatic test_mode0();
    logic [127:0] q;
    int lat;
    id_sbox = 1'b1;
    run_op({4{32'h8e4da1bc}}, '0, 2'd0, q, lat);
    tests++; if (lat !== 5) begin fails++; $display("FAIL mode0_latency got %0d exp 5", lat); end
    tests++; if (q !== {4{32'hdb135345}}) begin fails++; $display("FAIL mode0_data got %h exp %h", q, {4{32'hdb135345}}); end
    tick();
    id_sbox = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] d, k, q, prev;
    logic [1:0] m;
    int lat;
    for (int n = 0; n < 24; n++) begin
      d = rnd128();
      k = rnd128();
      m = 2'($urandom_range(0, 3));
      id_sbox = 1'($urandom_range(0, 1));
      run_op(d, k, m, q, lat);
      tests++; if (lat !== 5) begin fails++; $display("FAIL rand_latency[%0d] got %0d exp 5", n, lat); end
      tests++; if (q !== model(d, k, m, id_sbox)) begin
        fails++; $display("FAIL rand_data[%0d] mode %0d got %h exp %h", n, m, q, model(d, k, m, id_sbox));
      end
      prev = q;
      tick();
      tick();
      tests++; if (done !== 1'b0 || data_out !== prev) begin
        fails++; $display("FAIL rand_hold[%0d] got done=%b %h exp done=0 %h", n, done, data_out, prev);
      end
    end
    id_sbox = 1'b0;
  endtask

  task automatic test_ignore_start();
    logic [127:0] d, k, q;
    int dones;
    d = rnd128();
    k = rnd128();
    data_in = d;
    round_key = k;
    round_mode = 2'd0;
    start = 1'b1;
    tick();
    dones = 0;
    q = '0;
    for (int i = 1; i <= 12; i++) begin
      start = (i == 2 || i == 4);
      data_in = rnd128();
      round_key = rnd128();
      round_mode = 2'($urandom_range(0, 3));
      tick();
      if (done) begin dones++; q = data_out; end
    end
    start = 1'b0;
    tests++; if (dones !== 1) begin fails++; $display("FAIL ignore_done_count got %0d exp 1", dones); end
    tests++; if (q !== model(d, k, 2'd0, 1'b0)) begin
      fails++; $display("FAIL ignore_data got %h exp %h", q, model(d, k, 2'd0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d1, k1, d2, k2, q1, q2;
    int lat1, lat2;
    d1 = rnd128(); k1 = rnd128(); d2 = rnd128(); k2 = rnd128();
    run_op(d1, k1, 2'd3, q1, lat1);
    run_op(d2, k2, 2'd1, q2, lat2);
    tests++; if (q1 !== model(d1, k1, 2'd3, 1'b0)) begin fails++; $display("FAIL b2b_first got %h exp %h", q1, model(d1, k1, 2'd3, 1'b0)); end
    tests++; if (lat2 !== 5) begin fails++; $display("FAIL b2b_latency got %0d exp 5", lat2); end
    tests++; if (q2 !== model(d2, k2, 2'd1, 1'b0)) begin fails++; $display("FAIL b2b_second got %h exp %h", q2, model(d2, k2, 2'd1, 1'b0)); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] d, k, q;
    int lat, dones;
    data_in = rnd128();
    round_key = rnd128();
    round_mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b exp 0", busy); end
    tests++; if (data_out !== '0) begin fails++; $display("FAIL midreset_data_out got %h exp 0", data_out); end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      tick();
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL midreset_done got %0d pulses exp 0", dones); end
    d = rnd128();
    k = rnd128();
    run_op(d, k, 2'd0, q, lat);
    tests++; if (lat !== 5) begin fails++; $display("FAIL midreset_latency got %0d exp 5", lat); end
    tests++; if (q !== model(d, k, 2'd0, 1'b0)) begin fails++; $display("FAIL midreset_data got %h exp %h", q, model(d, k, 2'd0, 1'b0)); end
    tick();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_mode2();
    test_mode1();
    test_mode0();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
